// File: rtl/lipsi_prog_loader.sv
// Serial program loader for Lipsi: a UART 8N1 receiver feeding instruction-memory writes, with the CPU held in reset until the image is in.
// Optional checksum byte after the image is enabled by defining LIPSI_LOADER_CHECKSUM_EN.
//
// state   | meaning
// IDLE    | waiting for the length byte, CPU held in reset
// LOAD    | writing data bytes to consecutive addresses
// CHECK   | waiting for the checksum byte (LIPSI_LOADER_CHECKSUM_EN only)
// DONE    | image loaded, CPU released; a new byte restarts the load
// ERR     | framing or checksum error, sticky until reset
module lipsi_prog_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  // Wide enough for both the raw length byte and the 2^ADDR_W full-image count
  localparam int LW = (ADDR_W >= 8) ? ADDR_W + 1 : 9;
  localparam logic [LW-1:0] FULL_LEN = LW'(2 ** ADDR_W);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

`ifdef LIPSI_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {L_IDLE, L_LOAD, L_CHECK, L_DONE, L_ERR} ld_state_t;
`else
  typedef enum logic [1:0] {L_IDLE, L_LOAD, L_DONE, L_ERR} ld_state_t;
`endif

  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_t       rx_state_q, rx_state_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_stb, frame_err;

  ld_state_t       state_q, state_d;
  logic [LW-1:0]   len_q, len_d;
  logic            wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]      wr_data_q, wr_data_d;
  logic            cpu_reset_q, cpu_reset_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
`ifdef LIPSI_LOADER_CHECKSUM_EN
  logic [7:0]      sum_q, sum_d;
`endif

  always_comb begin
    rx_state_d = rx_state_q;
    bit_cnt_d  = bit_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    byte_stb   = 1'b0;
    frame_err  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          bit_cnt_d  = HALF_LAST;
        end
      end
      RX_START: begin
        if (bit_cnt_q == '0) begin
          if (!rx_sync_q) begin
            rx_state_d = RX_DATA;
            bit_cnt_d  = BIT_LAST;
            bit_idx_d  = 3'd0;
          end else begin
            rx_state_d = RX_IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - CW'(1);
        end
      end
      RX_DATA: begin
        if (bit_cnt_q == '0) begin
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_cnt_d = BIT_LAST;
          if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
          else                   bit_idx_d  = bit_idx_q + 3'd1;
        end else begin
          bit_cnt_d = bit_cnt_q - CW'(1);
        end
      end
      RX_STOP: begin
        if (bit_cnt_q == '0) begin
          rx_state_d = RX_IDLE;
          byte_stb   = rx_sync_q;
          frame_err  = !rx_sync_q;
        end else begin
          bit_cnt_d = bit_cnt_q - CW'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      bit_cnt_q  <= '0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
    end
  end

  // The loader acts on the stop-sample cycle itself so wr_en lands one cycle later.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    wr_addr_d = wr_en_q ? wr_addr_q + ADDR_W'(1) : wr_addr_q;
`ifdef LIPSI_LOADER_CHECKSUM_EN
    sum_d     = sum_q;
`endif
    case (state_q)
      L_IDLE, L_DONE: begin
        if (byte_stb) begin
          len_d     = (shift_q == 8'h00) ? FULL_LEN : LW'(shift_q);
          wr_addr_d = '0;
          state_d   = L_LOAD;
`ifdef LIPSI_LOADER_CHECKSUM_EN
          sum_d     = 8'h00;
`endif
        end
      end
      L_LOAD: begin
        if (byte_stb) begin
          wr_en_d   = 1'b1;
          wr_data_d = shift_q;
          len_d     = len_q - LW'(1);
`ifdef LIPSI_LOADER_CHECKSUM_EN
          sum_d     = sum_q + shift_q;
          if (len_q == LW'(1)) state_d = L_CHECK;
`else
          if (len_q == LW'(1)) state_d = L_DONE;
`endif
        end
      end
`ifdef LIPSI_LOADER_CHECKSUM_EN
      L_CHECK: begin
        if (byte_stb) state_d = (shift_q == sum_q) ? L_DONE : L_ERR;
      end
`endif
      default: ;
    endcase
    if (frame_err && state_q != L_ERR) state_d = L_ERR;

    // DONE is reported only once the state has settled there, one cycle after the last write
    done_d      = (state_q == L_DONE) && (state_d == L_DONE);
    cpu_reset_d = !done_d;
    err_d       = (state_d == L_ERR);
`ifdef LIPSI_LOADER_CHECKSUM_EN
    busy_d      = (state_d == L_LOAD) || (state_d == L_CHECK);
`else
    busy_d      = (state_d == L_LOAD);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= L_IDLE;
      len_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'h00;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef LIPSI_LOADER_CHECKSUM_EN
      sum_q       <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef LIPSI_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign cpu_reset = cpu_reset_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_lipsi_prog_loader.sv
// Bench for lipsi_prog_loader: UART byte driver, write scoreboard and status checks.
module tb_lipsi_prog_loader;
  localparam int CPB = 4;
  localparam int AW  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          cpu_reset, busy, done, err;

  lipsi_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .rx(rx), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .cpu_reset(cpu_reset), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
    bit            last;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] img[$];
  int         total = 0;
  int         bad = 0;
  bit         chk_done_next = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_done_next) begin
      chk_done_next = 1'b0;
      check_val("done_after_last", done, 1);
      check_val("cpu_rel_after_last", cpu_reset, 0);
    end
    if (wr_en === 1'b1) begin
      wr_t e;
      check_val("wr_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_val("wr_addr", wr_addr, e.addr);
        check_val("wr_data", wr_data, e.data);
        check_val("cpu_held_in_wr", cpu_reset, 1);
        if (e.last) chk_done_next = 1'b1;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_ok;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic push_wr(input int a, input logic [7:0] d, input bit last);
    wr_t e;
    e.addr = AW'(a);
    e.data = d;
    e.last = last;
    exp_q.push_back(e);
  endtask

  // Sends length plus img[], and the checksum byte when that build option is on.
  task automatic load_image(input logic [7:0] len);
    logic [7:0] sum;
    bit         csum;
    sum = 8'h00;
`ifdef LIPSI_LOADER_CHECKSUM_EN
    csum = 1'b1;
`else
    csum = 1'b0;
`endif
    send_byte(len, 1'b1);
    for (int i = 0; i < img.size(); i++) begin
      push_wr(i, img[i], (i == img.size() - 1) && !csum);
      sum = sum + img[i];
      send_byte(img[i], 1'b1);
    end
    if (csum) send_byte(sum, 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outs(input string tag);
    check_val({tag, "_wr_en"}, wr_en, 0);
    check_val({tag, "_wr_addr"}, wr_addr, 0);
    check_val({tag, "_wr_data"}, wr_data, 0);
    check_val({tag, "_cpu_reset"}, cpu_reset, 1);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_done"}, done, 0);
    check_val({tag, "_err"}, err, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    rx = 1'b1;
    @(negedge clk);
    check_reset_outs("rst");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // one-cycle glitch in IDLE
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (CPB * 12) @(negedge clk);
    check_val("glitch_busy", busy, 0);
    check_val("glitch_cpu_reset", cpu_reset, 1);
    check_val("glitch_done", done, 0);

    // normal load; also proves the FSM stayed in IDLE after the glitch
    img = '{8'hC7, 8'h0A, 8'hFF};
    load_image(8'h03);
    check_val("norm_done", done, 1);
    check_val("norm_cpu_reset", cpu_reset, 0);
    check_val("norm_busy", busy, 0);
    check_val("norm_sb_empty", exp_q.size(), 0);

    // reload from DONE
    send_byte(8'h01, 1'b1);
    check_val("reload_cpu_reset", cpu_reset, 1);
    check_val("reload_done", done, 0);
    check_val("reload_busy", busy, 1);
`ifdef LIPSI_LOADER_CHECKSUM_EN
    push_wr(0, 8'hAA, 1'b0);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hAA, 1'b1);
`else
    push_wr(0, 8'hAA, 1'b1);
    send_byte(8'hAA, 1'b1);
`endif
    check_val("reload_done_end", done, 1);
    check_val("reload_sb_empty", exp_q.size(), 0);

    // full image, length byte 0 means 2^AW
    do_reset();
    img.delete();
    for (int i = 0; i < 16; i++) img.push_back(8'(i));
    load_image(8'h00);
    check_val("full_done", done, 1);
    check_val("full_addr_wrap", wr_addr, 0);
    check_val("full_sb_empty", exp_q.size(), 0);

    // reset in the middle of a byte
    do_reset();
    send_byte(8'h05, 1'b1);
    push_wr(0, 8'h11, 1'b0);
    send_byte(8'h11, 1'b1);
    push_wr(1, 8'h22, 1'b0);
    send_byte(8'h22, 1'b1);
    check_val("mid_busy_before", busy, 1);
    check_val("mid_sb_empty", exp_q.size(), 0);
    rx = 1'b0;
    repeat (CPB * 3) @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_outs("mid");
    @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (CPB * 12) @(negedge clk);
    img = '{8'h5A};
    load_image(8'h01);
    check_val("after_mid_done", done, 1);

    // framing error
    do_reset();
    send_byte(8'h02, 1'b1);
    send_byte(8'h55, 1'b0);
    check_val("frm_err", err, 1);
    check_val("frm_cpu_reset", cpu_reset, 1);
    check_val("frm_busy", busy, 0);
    check_val("frm_done", done, 0);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    check_val("frm_err_sticky", err, 1);
    check_val("frm_done_sticky", done, 0);

`ifdef LIPSI_LOADER_CHECKSUM_EN
    do_reset();
    send_byte(8'h02, 1'b1);
    push_wr(0, 8'h10, 1'b0);
    send_byte(8'h10, 1'b1);
    push_wr(1, 8'h20, 1'b0);
    send_byte(8'h20, 1'b1);
    check_val("cs_busy_check", busy, 1);
    send_byte(8'h30, 1'b1);
    check_val("cs_ok_done", done, 1);
    check_val("cs_ok_err", err, 0);

    do_reset();
    send_byte(8'h02, 1'b1);
    push_wr(0, 8'h10, 1'b0);
    send_byte(8'h10, 1'b1);
    push_wr(1, 8'h20, 1'b0);
    send_byte(8'h20, 1'b1);
    send_byte(8'h31, 1'b1);
    check_val("cs_bad_err", err, 1);
    check_val("cs_bad_done", done, 0);
    check_val("cs_bad_cpu_reset", cpu_reset, 1);
`endif

    repeat (4) @(negedge clk);
    check_val("final_sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
